// File: rtl/noc_vc_input_port.sv
// Virtual-channel NoC input port: one first-word-fall-through FIFO per VC, packet-locked
// round-robin output arbitration, registered per-VC credit return and a sticky overflow flag.
module noc_vc_input_port #(
  parameter int NUM_VCS           = 2,
  parameter int FLIT_WIDTH        = 128,
  parameter int DEST_WIDTH        = 6,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int VC_WIDTH          = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                  clk_noc,
  input  logic                  rst_noc,
  input  logic                  send_in,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic [VC_WIDTH-1:0]   vc_in,
  output logic [NUM_VCS-1:0]    credit_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLIT_WIDTH-1:0] out_data,
  output logic [DEST_WIDTH-1:0] out_dest,
  output logic                  out_is_tail,
  output logic [VC_WIDTH-1:0]   out_vc,
  output logic                  overflow_err
);

  localparam int                  DEPTH    = FLIT_BUFFER_DEPTH;
  localparam int                  PTR_W    = $clog2(DEPTH);
  localparam int                  CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DEPTH);
  localparam logic [VC_WIDTH-1:0] LAST_VC  = VC_WIDTH'(NUM_VCS - 1);

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;
  } flit_t;

  typedef enum logic {UNLOCKED, LOCKED} arb_state_e;

  flit_t            mem_q    [NUM_VCS][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_VCS];
  logic [PTR_W-1:0] wr_ptr_d [NUM_VCS];
  logic [PTR_W-1:0] rd_ptr_q [NUM_VCS];
  logic [PTR_W-1:0] rd_ptr_d [NUM_VCS];
  logic [CNT_W-1:0] count_q  [NUM_VCS];
  logic [CNT_W-1:0] count_d  [NUM_VCS];

  arb_state_e          state_q, state_d;
  logic [VC_WIDTH-1:0] lock_vc_q, lock_vc_d;
  logic [VC_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                hold_q, hold_d;
  logic [VC_WIDTH-1:0] hold_vc_q, hold_vc_d;
  logic [NUM_VCS-1:0]  credit_q;
  logic                overflow_q, overflow_d;

  logic [NUM_VCS-1:0]  nonempty;
  logic [NUM_VCS-1:0]  wr_en;
  logic [NUM_VCS-1:0]  pop_vec;
  logic [VC_WIDTH-1:0] rr_grant;
  logic [VC_WIDTH-1:0] rr_idx;
  logic                rr_found;
  logic [VC_WIDTH-1:0] grant;
  logic                valid;
  logic                pop;
  flit_t               flit_in;
  flit_t               head;

  assign flit_in = '{data: data_in, dest: dest_in, is_tail: is_tail_in};

  // Round-robin search for the first non-empty VC starting at rr_ptr.
  // NOTE: every signal driven in an always_comb is given a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    rr_grant = rr_ptr_q;
    rr_found = 1'b0;
    rr_idx   = rr_ptr_q;
    for (int i = 0; i < NUM_VCS; i++) begin
      if (!rr_found && nonempty[rr_idx]) begin
        rr_found = 1'b1;
        rr_grant = rr_idx;
      end
      rr_idx = (rr_idx == LAST_VC) ? '0 : rr_idx + 1'b1;
    end
  end

  // A lock pins the grant to one VC; a stalled unlocked grant is held so outputs stay stable.
  always_comb begin
    grant = rr_grant;
    valid = rr_found;
    if (state_q == LOCKED) begin
      grant = lock_vc_q;
      valid = nonempty[lock_vc_q];
    end else if (hold_q) begin
      grant = hold_vc_q;
      valid = nonempty[hold_vc_q];
    end
  end

  assign head = mem_q[grant][rd_ptr_q[grant]];
  assign pop  = valid && out_ready;

  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      nonempty[v] = (count_q[v] != '0);
      pop_vec[v]  = pop && (grant == VC_WIDTH'(v));
      wr_en[v]    = send_in && (vc_in == VC_WIDTH'(v)) && ((count_q[v] != FULL_CNT) || pop_vec[v]);
      wr_ptr_d[v] = wr_en[v] ? wr_ptr_q[v] + 1'b1 : wr_ptr_q[v];
      rd_ptr_d[v] = pop_vec[v] ? rd_ptr_q[v] + 1'b1 : rd_ptr_q[v];
      unique case ({wr_en[v], pop_vec[v]})
        2'b10:   count_d[v] = count_q[v] + 1'b1;
        2'b01:   count_d[v] = count_q[v] - 1'b1;
        default: count_d[v] = count_q[v];
      endcase
    end
  end

  // A flit with no accepting FIFO (full without a same-cycle pop, or an out-of-range VC) is dropped.
  assign overflow_d = overflow_q || (send_in && (wr_en == '0));

  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    rr_ptr_d  = rr_ptr_q;
    hold_d    = valid && !out_ready && (state_q == UNLOCKED);
    hold_vc_d = grant;
    if (pop) begin
      if (head.is_tail) begin
        state_d  = UNLOCKED;
        rr_ptr_d = (grant == LAST_VC) ? '0 : grant + 1'b1;
      end else begin
        state_d   = LOCKED;
        lock_vc_d = grant;
      end
    end
  end

  // NOTE: flit storage has no reset; the reset counts and pointers already mark every entry empty.
  always_ff @(posedge clk_noc) begin
    for (int v = 0; v < NUM_VCS; v++) begin
      if (wr_en[v]) mem_q[v][wr_ptr_q[v]] <= flit_in;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        count_q[v]  <= '0;
      end
      state_q    <= UNLOCKED;
      lock_vc_q  <= '0;
      rr_ptr_q   <= '0;
      hold_q     <= 1'b0;
      hold_vc_q  <= '0;
      credit_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        count_q[v]  <= count_d[v];
      end
      state_q    <= state_d;
      lock_vc_q  <= lock_vc_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_q     <= hold_d;
      hold_vc_q  <= hold_vc_d;
      credit_q   <= pop_vec;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid    = valid;
  assign out_data     = head.data;
  assign out_dest     = head.dest;
  assign out_is_tail  = head.is_tail;
  assign out_vc       = grant;
  assign credit_out   = credit_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_noc_vc_input_port.sv
// Directed bench for noc_vc_input_port: per-VC expected-flit queues filled at send time and
// drained by a negedge monitor that also checks credit timing and packet non-interleaving.
module tb_noc_vc_input_port;

  localparam int NV = 2;
  localparam int FW = 128;
  localparam int DW = 6;
  localparam int VW = 1;

  logic          clk_noc = 1'b0;
  logic          rst_noc;
  logic          send_in = 1'b0;
  logic [FW-1:0] data_in = '0;
  logic [DW-1:0] dest_in = '0;
  logic          is_tail_in = 1'b0;
  logic [VW-1:0] vc_in = '0;
  logic [NV-1:0] credit_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [FW-1:0] out_data;
  logic [DW-1:0] out_dest;
  logic          out_is_tail;
  logic [VW-1:0] out_vc;
  logic          overflow_err;

  noc_vc_input_port #(
    .NUM_VCS(NV), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(4)
  ) dut (
    .clk_noc(clk_noc), .rst_noc(rst_noc), .send_in(send_in), .data_in(data_in),
    .dest_in(dest_in), .is_tail_in(is_tail_in), .vc_in(vc_in), .credit_out(credit_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dest(out_dest),
    .out_is_tail(out_is_tail), .out_vc(out_vc), .overflow_err(overflow_err)
  );

  always #5 clk_noc = ~clk_noc;

  typedef struct {
    logic [FW-1:0] data;
    logic [DW-1:0] dest;
    logic          tail;
  } exp_t;

  exp_t          exp0[$];
  exp_t          exp1[$];
  int            order_log[$];
  int            n_tests = 0;
  int            n_fail = 0;
  int            cred_cnt[NV] = '{0, 0};
  logic [NV-1:0] pend_credit = '0;
  logic          lock_valid = 1'b0;
  int            lock_vc = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int n);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(n);
    return {w, w, w, w};
  endfunction

  task automatic send(input int vc, input int n, input logic tail, input logic accept);
    exp_t e;
    e.data = mk(n);
    e.dest = DW'(n);
    e.tail = tail;
    send_in    = 1'b1;
    data_in    = e.data;
    dest_in    = e.dest;
    is_tail_in = tail;
    vc_in      = VW'(vc);
    if (accept) begin
      if (vc == 0) exp0.push_back(e);
      else         exp1.push_back(e);
    end
    @(posedge clk_noc); #1;
    send_in = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && c < 50) begin
      @(posedge clk_noc); #1;
      c++;
    end
    check("drain_in_budget", c < 50, 1'b1);
    repeat (2) begin
      @(posedge clk_noc); #1;
    end
  endtask

  task automatic check_order(input int n, input logic [7:0] vcs);
    check("order_len", order_log.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < order_log.size()) check($sformatf("order_vc_%0d", i), order_log[i], vcs[i]);
    end
  endtask

  // Monitor: a pop decided at this negedge must show up as a credit at the next one.
  always @(negedge clk_noc) begin
    exp_t e;
    if (rst_noc) begin
      pend_credit = '0;
      lock_valid  = 1'b0;
    end else begin
      check("credit_out", credit_out, pend_credit);
      for (int v = 0; v < NV; v++) if (credit_out[v]) cred_cnt[v]++;
      pend_credit = '0;
      if (out_valid && out_ready) begin
        pend_credit[out_vc] = 1'b1;
        order_log.push_back(int'(out_vc));
        if (lock_valid) check("no_interleave", out_vc, lock_vc);
        lock_valid = !out_is_tail;
        lock_vc    = int'(out_vc);
        check("pop_expected", (out_vc == 0) ? exp0.size() != 0 : exp1.size() != 0, 1'b1);
        if (out_vc == 0 && exp0.size() != 0) e = exp0.pop_front();
        else if (out_vc == 1 && exp1.size() != 0) e = exp1.pop_front();
        else e = '{data: '0, dest: '0, tail: 1'b0};
        check("out_data", out_data, e.data);
        check("out_dest", out_dest, e.dest);
        check("out_is_tail", out_is_tail, e.tail);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_noc = 1'b0;
    #1 rst_noc = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_credit", credit_out, 2'b00);
    check("rst_overflow", overflow_err, 1'b0);
    repeat (2) @(posedge clk_noc);
    #3 rst_noc = 1'b0;

    // 3-flit packet on VC1, accepted on the first edge after reset release.
    out_ready = 1'b1;
    cred_cnt  = '{0, 0};
    send(1, 1, 1'b0, 1'b1);
    check("fwft_valid", out_valid, 1'b1);
    check("fwft_vc", out_vc, 1'b1);
    check("fwft_data", out_data, mk(1));
    send(1, 2, 1'b0, 1'b1);
    send(1, 3, 1'b1, 1'b1);
    drain();
    check("pkt_credits_vc1", cred_cnt[1], 3);
    check("pkt_credits_vc0", cred_cnt[0], 0);

    // Alternating arrival of packet A (VC0) and B (VC1): whole packets, A first.
    out_ready = 1'b0;
    order_log.delete();
    send(0, 10, 1'b0, 1'b1);
    send(1, 11, 1'b0, 1'b1);
    send(0, 12, 1'b0, 1'b1);
    send(1, 13, 1'b1, 1'b1);
    send(0, 14, 1'b1, 1'b1);
    out_ready = 1'b1;
    drain();
    check_order(5, 8'b0001_1000);

    // Round-robin advance: after VC0's tail, VC1 goes before VC0's next packet.
    out_ready = 1'b0;
    order_log.delete();
    send(0, 15, 1'b1, 1'b1);
    send(1, 16, 1'b1, 1'b1);
    send(0, 17, 1'b1, 1'b1);
    out_ready = 1'b1;
    drain();
    check_order(3, 8'b0000_0010);

    // Overflow: five sends into a 4-deep FIFO with no draining.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 20 + i, 1'b1, 1'b1);
    check("ovf_not_yet", overflow_err, 1'b0);
    send(0, 24, 1'b1, 1'b0);
    check("ovf_set", overflow_err, 1'b1);
    cred_cnt = '{0, 0};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_noc); #1;
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, mk(20));
      check("stall_dest", out_dest, 6'(20));
      check("stall_vc", out_vc, 1'b0);
    end
    check("stall_no_credit", cred_cnt[0], 0);
    out_ready = 1'b1;
    drain();
    check("ovf_drain_credits", cred_cnt[0], 4);
    check("ovf_sticky", overflow_err, 1'b1);

    rst_noc = 1'b1;
    #1;
    check("rst2_overflow", overflow_err, 1'b0);
    check("rst2_valid", out_valid, 1'b0);
    repeat (2) @(posedge clk_noc);
    #3 rst_noc = 1'b0;

    // Full FIFO with a same-cycle pop still accepts the write and stays full.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 30 + i, 1'b1, 1'b1);
    cred_cnt  = '{0, 0};
    out_ready = 1'b1;
    send(0, 34, 1'b1, 1'b1);
    out_ready = 1'b0;
    check("full_pop_no_ovf", overflow_err, 1'b0);
    send(0, 35, 1'b1, 1'b0);
    check("still_full_ovf", overflow_err, 1'b1);
    out_ready = 1'b1;
    drain();
    check("full_pop_credits", cred_cnt[0], 5);

    // Locked on empty VC0: VC1 must not be presented until VC0 gets its next flit.
    order_log.delete();
    send(0, 40, 1'b0, 1'b1);
    send(1, 41, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("locked_empty_stall", out_valid, 1'b0);
      @(posedge clk_noc); #1;
    end
    send(0, 42, 1'b1, 1'b1);
    check("locked_resume_valid", out_valid, 1'b1);
    check("locked_resume_vc", out_vc, 1'b0);
    drain();
    check_order(3, 8'b0000_0100);

    // Asynchronous reset between edges in the middle of a VC0 packet.
    send(0, 50, 1'b0, 1'b1);
    send(0, 51, 1'b0, 1'b1);
    check("pre_rst_credit", credit_out, 2'b01);
    check("pre_rst_valid", out_valid, 1'b1);
    #2 rst_noc = 1'b1;
    exp0.delete();
    exp1.delete();
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_credit", credit_out, 2'b00);
    check("async_rst_overflow", overflow_err, 1'b0);
    repeat (2) @(posedge clk_noc);
    #3 rst_noc = 1'b0;
    cred_cnt = '{0, 0};
    send(1, 60, 1'b1, 1'b1);
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_vc", out_vc, 1'b1);
    check("post_rst_tail", out_is_tail, 1'b1);
    drain();
    check("post_rst_credit_vc1", cred_cnt[1], 1);
    check("post_rst_credit_vc0", cred_cnt[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_vc_input_port.md
NOC_VC_INPUT_PORT -- requirements
Module: noc_vc_input_port

Interface
REQ-001 SHALL have parameter NUM_VCS, default 2, number of virtual channels (1..8).
REQ-002 SHALL have parameter FLIT_WIDTH, default 128, flit payload bits.
REQ-003 SHALL have parameter DEST_WIDTH, default 6, destination field bits.
REQ-004 SHALL have parameter FLIT_BUFFER_DEPTH, default 4, flits per VC FIFO (power of 2, >=2).
REQ-005 SHALL have derived parameter VC_WIDTH, default max(1,clog2(NUM_VCS)), VC index bits.
REQ-006 SHALL have port clk_noc  input  1  NoC clock; one clock only, all logic on rising edge.
REQ-007 SHALL have port rst_noc  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port send_in  input  1  upstream flit valid this cycle.
REQ-009 SHALL have port data_in  input  FLIT_WIDTH  flit payload.
REQ-010 SHALL have port dest_in  input  DEST_WIDTH  flit destination.
REQ-011 SHALL have port is_tail_in  input  1  last flit of packet.
REQ-012 SHALL have port vc_in  input  VC_WIDTH  target VC of flit.
REQ-013 SHALL have port credit_out  output  NUM_VCS  per-VC one-cycle credit-return pulse.
REQ-014 SHALL have port out_valid  output  1  head flit available downstream.
REQ-015 SHALL have port out_ready  input  1  downstream accepts flit.
REQ-016 SHALL have ports out_data (FLIT_WIDTH), out_dest (DEST_WIDTH), out_is_tail (1), out_vc (VC_WIDTH), all outputs, describing the presented flit.
REQ-017 SHALL have port overflow_err  output  1  sticky error flag.

Function
REQ-018 SHALL hold one FIFO per VC storing {data, dest, is_tail}; count width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-019 SHALL write flit into FIFO vc_in when send_in=1 and (count<DEPTH or that VC pops in same cycle).
REQ-020 SHALL drop the flit and set overflow_err when send_in=1 and FIFO full with no same-cycle pop, or vc_in>=NUM_VCS; overflow_err clears only on reset.
REQ-021 SHALL present the head flit first-word-fall-through: flit written at edge t visible on outputs after edge t, pop possible at edge t+1 (1-cycle minimum latency).
REQ-022 SHALL pop the granted VC head on each edge where out_valid=1 and out_ready=1.
REQ-023 SHALL hold out_data/out_dest/out_is_tail/out_vc stable while out_valid=1 and out_ready=0.
REQ-024 SHALL implement arbiter FSM with states UNLOCKED and LOCKED(vc).
REQ-025 UNLOCKED: grant the first non-empty VC searching round-robin from rr_ptr; out_valid=1 iff any VC non-empty.
REQ-026 UNLOCKED, pop of non-tail flit: go LOCKED(granted vc); pop of tail flit: stay UNLOCKED.
REQ-027 LOCKED(v): grant only v; out_valid=1 iff FIFO v non-empty; other VCs never presented, even if v empty.
REQ-028 LOCKED(v), pop of tail: go UNLOCKED, rr_ptr <= (v+1) mod NUM_VCS.
REQ-029 UNLOCKED tail pop from VC g SHALL also set rr_ptr <= (g+1) mod NUM_VCS; rr_ptr unchanged otherwise.
REQ-030 SHALL pulse credit_out[v] for exactly one cycle, on the cycle after each pop from VC v (registered); no credit for dropped flits.
REQ-031 SHALL drive out_vc equal to the granted VC index; when out_valid=0 outputs are don't-care except out_valid.
REQ-032 Simultaneous write and pop on the same VC SHALL leave count unchanged and preserve order.

Reset
REQ-033 On rst_noc=1 (asynchronous): all counts/pointers 0, FSM UNLOCKED, rr_ptr 0, credit_out 0, overflow_err 0, out_valid 0.
REQ-034 Reset mid-packet SHALL discard all buffered flits and any lock; no credits issued for discarded flits.
REQ-035 First flit SHALL be accepted on the first edge after rst_noc deasserts.

Verification
REQ-036 NUM_VCS=2, DEPTH=4: 3-flit packet on VC1, out_ready=1 -> out_valid from cycle after first send, flits in order, out_vc=1, credit_out=2'b10 pulses 3 times, each one cycle after pop.
REQ-037 Interleave: VC0 packet A (3 flits) and VC1 packet B (2 flits) arriving alternately -> output is all of A then all of B (or B then A per rr_ptr), never interleaved; rr_ptr advances after each tail.
REQ-038 Overflow: 5 sends to VC0 with out_ready=0, DEPTH=4 -> 4 stored, 5th dropped, overflow_err=1 and stays 1; draining yields exactly 4 flits and 4 credits.
REQ-039 Full with simultaneous pop: VC0 full, out_ready=1 and send to VC0 same cycle -> write accepted, count stays 4, overflow_err=0.
REQ-040 Backpressure: out_ready=0 for 5 cycles with flit presented -> outputs stable, no credit; Locked-empty stall: LOCKED(0) with VC0 empty and VC1 non-empty -> out_valid=0 until VC0 flit arrives.
REQ-041 Async reset asserted mid-packet between edges -> out_valid=0, credit_out=0, overflow_err=0 immediately; after release, new single-flit tail packet on VC1 is output with out_vc=1.
